// File: rtl/reflet_pwm_multi.sv
// Multi-channel PWM: one shared up or up/down period counter, per-channel duty compare,
// and double-buffered max/duty/mode that take effect only at a period boundary.
module reflet_pwm_multi #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      update,
    input  logic [WIDTH-1:0]          max_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      center_in,
    input  logic [CHANNELS-1:0]       invert,
    output logic                      update_pending,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       out
);

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      dir_q, dir_d;  // 0 = counting up, 1 = counting down
    logic [WIDTH-1:0]          max_q, max_d, max_s_q, max_s_d;
    logic [CHANNELS*WIDTH-1:0] duty_q, duty_d, duty_s_q, duty_s_d;
    logic                      center_q, center_d, center_s_q, center_s_d;
    logic                      pending_q, pending_d;
    logic                      start_q, start_d;
    logic [CHANNELS-1:0]       out_q, out_d;
    logic                      boundary;

    always_comb begin
        // While idle every cycle counts as a boundary so staged values apply at once.
        if (!enable) begin
            boundary = 1'b1;
        end else if (center_q) begin
            // cnt==max==1 going up also returns straight to 0.
            boundary = (max_q == '0) ||
                       ((cnt_q == WIDTH'(1)) && (dir_q || (cnt_q == max_q)));
        end else begin
            boundary = (cnt_q == max_q);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (boundary) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (!center_q) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!dir_q) begin
            if (cnt_q == max_q) begin
                cnt_d = cnt_q - 1'b1;
                dir_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        max_d      = max_q;
        duty_d     = duty_q;
        center_d   = center_q;
        max_s_d    = max_s_q;
        duty_s_d   = duty_s_q;
        center_s_d = center_s_q;
        pending_d  = pending_q;
        if (update && boundary) begin
            max_d      = max_in;
            duty_d     = duty_in;
            center_d   = center_in;
            max_s_d    = max_in;
            duty_s_d   = duty_in;
            center_s_d = center_in;
            pending_d  = 1'b0;
        end else if (boundary && pending_q) begin
            max_d     = max_s_q;
            duty_d    = duty_s_q;
            center_d  = center_s_q;
            pending_d = 1'b0;
        end else if (update) begin
            max_s_d    = max_in;
            duty_s_d   = duty_in;
            center_s_d = center_in;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (enable) begin
                out_d[i] = (cnt_q < duty_q[i*WIDTH +: WIDTH]) ^ invert[i];
            end else begin
                out_d[i] = invert[i];
            end
        end
        start_d = enable && (cnt_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            max_q      <= '0;
            duty_q     <= '0;
            center_q   <= 1'b0;
            max_s_q    <= '0;
            duty_s_q   <= '0;
            center_s_q <= 1'b0;
            pending_q  <= 1'b0;
            start_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            max_q      <= max_d;
            duty_q     <= duty_d;
            center_q   <= center_d;
            max_s_q    <= max_s_d;
            duty_s_q   <= duty_s_d;
            center_s_q <= center_s_d;
            pending_q  <= pending_d;
            start_q    <= start_d;
            out_q      <= out_d;
        end
    end

    assign update_pending = pending_q;
    assign period_start   = start_q;
    assign out            = out_q;

endmodule
